// File: rtl/sha_compress_pkg.sv
// Shared widths, FSM encoding and SHA-256 bit-mixing helpers for the compression stage.
package sha_compress_pkg;

  localparam int WORD_S = 32;
  localparam int WARR_S = 64 * WORD_S;
  localparam int H_SIZE = 8 * WORD_S;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  // Message-schedule mixers, used by the upstream schedule stage.
  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha_k_rom.sv
// Combinational 64 x 32 SHA-256 round-constant lookup, addressed by the round counter.
module sha_k_rom #(
  parameter int unsigned CNT_W = 6
) (
  input  logic [CNT_W-1:0] addr,
  output logic [31:0]      k
);

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  always_comb begin
    k = K_TAB[6'(addr)];
  end

endmodule

// File: rtl/sha_compress.sv
// SHA-256 compression: latches schedule/chaining value, runs one round per clock,
// then emits H + working vars with a single-cycle en_next pulse.
module sha_compress
  import sha_compress_pkg::*;
#(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WARR_S-1:0] W,
  input  logic [H_SIZE-1:0] Hin,
  input  logic [WORD_S-1:0] nonce,
  output logic              busy,
  output logic [H_SIZE-1:0] H,
  output logic [WORD_S-1:0] nonce_out,
  output logic              en_next
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  state_t            state, state_nx;
  logic              load, step, last, finish;
  logic [CNT_W-1:0]  cnt;
  logic [WARR_S-1:0] w_lat;
  logic [H_SIZE-1:0] h_lat;
  logic [WORD_S-1:0] nonce_lat;
  logic [31:0]       v [8];
  logic [31:0]       k_t, w_t, t1, t2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (cnt == LAST_CNT) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE) && en;
    step   = (state == RUN);
    last   = step && (cnt == LAST_CNT);
    finish = (state == DONE);
  end

  sha_k_rom #(.CNT_W(CNT_W)) u_k_rom (
    .addr (cnt),
    .k    (k_t)
  );

  // v[0..7] hold working variables a..h.
  always_comb begin
    w_t = w_lat[cnt*WORD_S +: WORD_S];
    t1  = v[7] + big_sig1(v[4]) + ch(v[4], v[5], v[6]) + k_t + w_t;
    t2  = big_sig0(v[0]) + maj(v[0], v[1], v[2]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      w_lat     <= '0;
      h_lat     <= '0;
      nonce_lat <= '0;
      for (int unsigned i = 0; i < 8; i++) v[i] <= '0;
      H         <= '0;
      nonce_out <= '0;
      en_next   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // busy lags the RUN state by one cycle so it drops exactly as en_next rises.
      busy    <= step;
      en_next <= finish;
      if (load) begin
        w_lat     <= W;
        h_lat     <= Hin;
        nonce_lat <= nonce;
        cnt       <= '0;
        for (int unsigned i = 0; i < 8; i++) v[i] <= Hin[H_SIZE-1-32*i -: 32];
      end else if (step) begin
        v[7] <= v[6];
        v[6] <= v[5];
        v[5] <= v[4];
        v[4] <= v[3] + t1;
        v[3] <= v[2];
        v[2] <= v[1];
        v[1] <= v[0];
        v[0] <= t1 + t2;
        cnt  <= last ? '0 : cnt + CNT_W'(1);
      end
      if (finish) begin
        for (int unsigned i = 0; i < 8; i++)
          H[H_SIZE-1-32*i -: 32] <= h_lat[H_SIZE-1-32*i -: 32] + v[i];
        nonce_out <= nonce_lat;
      end
    end
  end

endmodule

// File: tb/tb_sha_compress.sv
// Self-checking bench for sha_compress: known digests, random blocks against a
// whole-block reference model, and hand-written timing/abort sequences.
module tb_sha_compress;

  logic          clk;
  logic          reset;
  logic          en;
  logic [2047:0] W;
  logic [255:0]  Hin;
  logic [31:0]   nonce;
  logic          busy;
  logic [255:0]  H;
  logic [31:0]   nonce_out;
  logic          en_next;

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] last_h = '0;

  sha_compress #(.ROUNDS(64), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .W         (W),
    .Hin       (Hin),
    .nonce     (nonce),
    .busy      (busy),
    .H         (H),
    .nonce_out (nonce_out),
    .en_next   (en_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_H =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_H =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  typedef struct {
    logic [255:0]  hin;
    logic [2047:0] w;
    logic [31:0]   nonce;
    logic [255:0]  exp_h;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Expand a 512-bit block (first word at the MSBs) into the packed 64-word schedule.
  function automatic logic [2047:0] ref_schedule(input logic [511:0] blk);
    logic [31:0] ws [64];
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) ws[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      ws[t] = (rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
            + (rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
    for (int t = 0; t < 64; t++) r[t*32 +: 32] = ws[t];
    return r;
  endfunction

  // Whole compression function: 64 rounds then feed-forward, all mod 2^32.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [2047:0] w);
    logic [31:0] hv [8];
    logic [31:0] s [8];
    logic [31:0] x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      hv[i] = hin[255-32*i -: 32];
      s[i]  = hv[i];
    end
    for (int t = 0; t < 64; t++) begin
      x1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + w[t*32 +: 32];
      x2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + x1;
      s[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + s[i];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [2047:0] rand2048();
    logic [2047:0] r;
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called between edges: presents the block, lets the next edge sample en, then scrambles inputs.
  task automatic launch(input vec_t v);
    W     = v.w;
    Hin   = v.hin;
    nonce = v.nonce;
    en    = 1'b1;
    @(posedge clk);
    #1;
    en    = 1'b0;
    W     = rand2048();
    Hin   = rand256();
    nonce = $urandom;
  endtask

  task automatic wait_done(input vec_t v, input int ghost_k, input bit chk_hold, input string tag);
    int k;
    bit got;
    bit busy_ok;
    k = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (k <= 64 && busy !== 1'b1) busy_ok = 1'b0;
      if (k >= 65 && busy !== 1'b0) busy_ok = 1'b0;
      if (k == 30) chk({tag, " hold_prev"}, H, last_h);
      if (en_next === 1'b1) got = 1'b1;
      if (ghost_k > 0 && k == ghost_k - 1) begin
        en  = 1'b1;
        W   = rand2048();
        Hin = rand256();
      end
      if (ghost_k > 0 && k == ghost_k) en = 1'b0;
    end
    chk({tag, " latency"}, 256'(k), 256'(65));
    chk({tag, " busy_profile"}, 256'(busy_ok), 256'(1));
    chk({tag, " H"}, H, v.exp_h);
    chk({tag, " nonce_out"}, 256'(nonce_out), 256'(v.nonce));
    if (chk_hold) begin
      @(posedge clk);
      #1;
      chk({tag, " en_next_pulse"}, 256'(en_next), 256'(0));
      chk({tag, " H_hold"}, H, v.exp_h);
    end
    last_h = v.exp_h;
  endtask

  initial begin
    bit seen;

    reset = 1'b0;
    en    = 1'b0;
    W     = '0;
    Hin   = '0;
    nonce = '0;
    #1;
    chk("reset H", H, 256'(0));
    chk("reset nonce_out", 256'(nonce_out), 256'(0));
    chk("reset busy", 256'(busy), 256'(0));
    chk("reset en_next", 256'(en_next), 256'(0));

    tbl[0] = '{hin: IV, w: ref_schedule({32'h61626380, 448'h0, 32'h00000018}),
               nonce: 32'hDEADBEEF, exp_h: ABC_H};
    tbl[1] = '{hin: IV, w: ref_schedule({32'h80000000, 480'h0}),
               nonce: $urandom, exp_h: EMPTY_H};
    tbl[2].hin   = '1;
    tbl[2].w     = '1;
    tbl[2].nonce = 32'hFFFFFFFF;
    tbl[2].exp_h = ref_compress(tbl[2].hin, tbl[2].w);
    for (int i = 3; i < 8; i++) begin
      tbl[i].hin   = (i == 7) ? ABC_H : rand256();
      tbl[i].w     = (i == 6) ? ref_schedule({rand256(), rand256()}) : rand2048();
      tbl[i].nonce = $urandom;
      tbl[i].exp_h = ref_compress(tbl[i].hin, tbl[i].w);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table pass; entries 0 -> 1 run back-to-back (en one cycle after en_next).
    for (int i = 0; i < 8; i++) begin
      launch(tbl[i]);
      wait_done(tbl[i], 0, (i != 0), $sformatf("vec%0d", i));
    end

    // Extra en during RUN must not re-latch.
    launch(tbl[0]);
    wait_done(tbl[0], 10, 1'b1, "ghost_run");

    // en sampled in the DONE cycle must be ignored.
    launch(tbl[1]);
    wait_done(tbl[1], 65, 1'b0, "ghost_done");
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (en_next !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("done_en_ignored", 256'(seen), 256'(0));

    // Reset mid-RUN: immediate clear, no en_next, clean restart afterwards.
    launch(tbl[2]);
    repeat (29) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset H", H, 256'(0));
    chk("midreset nonce_out", 256'(nonce_out), 256'(0));
    chk("midreset busy", 256'(busy), 256'(0));
    chk("midreset en_next", 256'(en_next), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (en_next !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("midreset no_en_next", 256'(seen), 256'(0));
    last_h = '0;
    launch(tbl[0]);
    wait_done(tbl[0], 0, 1'b1, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
